// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - RV32 5-stage hazard unit with M-extension occupancy control
// Forwarding, load-use stall, branch flush, MUL/DIV hold in E and saturating perf counters.
module hazard_unit_mc #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int MUL_LATENCY   = 2,
    parameter int DIV_LATENCY   = 34,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteE,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic                     MulE,
    input  logic                     DivE,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushM,
    output logic                     MdBusy,
    output logic [CNT_WIDTH-1:0]     StallCycles,
    output logic [CNT_WIDTH-1:0]     FlushEvents
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    md_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic [31:0] lat;
    logic        md_start;
    logic        lw_stall;
    logic        md_stall;
    logic        unused_result_src;

    assign unused_result_src = ResultSrcE[1];

    assign lat      = MulE ? 32'(MUL_LATENCY) : 32'(DIV_LATENCY);
    assign md_start = MulE | DivE;

    always_comb begin
        ForwardAE = 2'd0;
        if (Rs1E == RdM && RegWriteM && Rs1E != '0)
            ForwardAE = 2'd2;
        else if (Rs1E == RdW && RegWriteW && Rs1E != '0)
            ForwardAE = 2'd1;

        ForwardBE = 2'd0;
        if (Rs2E == RdM && RegWriteM && Rs2E != '0)
            ForwardBE = 2'd2;
        else if (Rs2E == RdW && RegWriteW && Rs2E != '0)
            ForwardBE = 2'd1;
    end

    assign lw_stall = ResultSrcE[0] & RegWriteE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));

    // The start cycle already stalls; DONE is the release cycle. Nothing is held while in reset.
    assign md_stall = rst_n & (((state_q == IDLE) & md_start & (lat >= 32'd2)) | (state_q == BUSY));

    assign StallF = lw_stall | md_stall;
    assign StallD = lw_stall | md_stall;
    assign StallE = md_stall;
    assign FlushM = md_stall;
    assign FlushD = PCSrcE & ~md_stall;
    assign FlushE = (lw_stall | PCSrcE) & ~md_stall;
    assign MdBusy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start && lat >= 32'd3) begin
                        state_q <= BUSY;
                        cnt_q   <= CW'(lat - 32'd3);
                    end else if (md_start && lat == 32'd2) begin
                        state_q <= DONE;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0)
                        state_q <= DONE;
                    else
                        cnt_q <= cnt_q - CW'(1);
                end
                // The same instruction is leaving E; it must not re-arm the controller.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (FlushD && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushEvents = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc
// Table-driven combinational vectors plus directed MUL/DIV, reset and saturation sequences.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MulE, DivE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;
    logic [31:0] StallCycles, FlushEvents;

    logic [1:0]  s_fa, s_fb;
    logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_busy;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.ADDRESS_WIDTH(5), .MUL_LATENCY(2), .DIV_LATENCY(34), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulE(MulE), .DivE(DivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MdBusy(MdBusy),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
    );

    // Narrow-counter copy fed with the same stimulus, used to observe saturation.
    hazard_unit_mc #(.ADDRESS_WIDTH(5), .MUL_LATENCY(2), .DIV_LATENCY(34), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulE(MulE), .DivE(DivE),
        .ForwardAE(s_fa), .ForwardBE(s_fb),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se),
        .FlushD(s_fd), .FlushE(s_fe), .FlushM(s_fm), .MdBusy(s_busy),
        .StallCycles(s_stall_cnt), .FlushEvents(s_flush_cnt)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww;
        logic [1:0] rsrc;
        logic       pc;
        logic [1:0] fa, fb;
        logic       st, fd, fe;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input int rwe, rwm, rww, rsrc, pc,
                                input int fa, fb, st, fd, fe);
        vec_t v;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
        v.rwe = 1'(rwe); v.rwm = 1'(rwm); v.rww = 1'(rww);
        v.rsrc = 2'(rsrc); v.pc = 1'(pc);
        v.fa = 2'(fa); v.fb = 2'(fb); v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MulE = 0; DivE = 0;
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic check_cycle(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                               input logic st, input logic ste, input logic fd,
                               input logic fe, input logic fm, input logic busy);
        chk({nm, ".ForwardAE"}, 32'(ForwardAE), 32'(fa));
        chk({nm, ".ForwardBE"}, 32'(ForwardBE), 32'(fb));
        chk({nm, ".StallF"}, 32'(StallF), 32'(st));
        chk({nm, ".StallD"}, 32'(StallD), 32'(st));
        chk({nm, ".StallE"}, 32'(StallE), 32'(ste));
        chk({nm, ".FlushD"}, 32'(FlushD), 32'(fd));
        chk({nm, ".FlushE"}, 32'(FlushE), 32'(fe));
        chk({nm, ".FlushM"}, 32'(FlushM), 32'(fm));
        chk({nm, ".MdBusy"}, 32'(MdBusy), 32'(busy));
        chk({nm, ".StallCycles"}, StallCycles, 32'(exp_stall));
        chk({nm, ".FlushEvents"}, FlushEvents, 32'(exp_flush));
        chk({nm, ".sat_StallCycles"}, 32'(s_stall_cnt), 32'(sat7(exp_stall)));
        chk({nm, ".sat_FlushEvents"}, 32'(s_flush_cnt), 32'(sat7(exp_flush)));
        exp_stall += int'(st);
        exp_flush += int'(fd);
    endtask

    // A full DIV held in E: stalled cycles 1..33, released on 34, busy 2..34.
    task automatic run_div(input string nm);
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            clr_inputs();
            DivE = 1;
            @(negedge clk);
            check_cycle(nm, 0, 0, i <= 33, i <= 33, 0, 0, i <= 33, i >= 2);
        end
        @(posedge clk); #1;
        clr_inputs();
        @(negedge clk);
        check_cycle({nm, ".after"}, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && MdBusy && PCSrcE) begin
            failures++;
            $display("FAIL illegal_branch_while_busy got=1 expected=0");
        end
    end

    initial begin
        vecs[0]  = mk(0,0,5,0,0,5,5, 0,1,1,0,0, 2,0,0,0,0);
        vecs[1]  = mk(0,0,5,0,0,5,5, 0,0,1,0,0, 1,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0, 0,1,1,0,0, 0,0,0,0,0);
        vecs[3]  = mk(0,0,4,3,0,4,3, 0,1,1,0,0, 2,1,0,0,0);
        vecs[4]  = mk(0,0,6,6,0,6,6, 0,0,0,0,0, 0,0,0,0,0);
        vecs[5]  = mk(0,7,0,0,7,0,0, 1,0,0,1,0, 0,0,1,0,1);
        vecs[6]  = mk(0,0,0,0,0,0,0, 1,0,0,1,0, 0,0,0,0,0);
        vecs[7]  = mk(7,0,0,0,7,0,0, 0,0,0,1,0, 0,0,0,0,0);
        vecs[8]  = mk(7,0,0,0,7,0,0, 1,0,0,2,0, 0,0,0,0,0);
        vecs[9]  = mk(9,0,0,0,9,0,0, 1,0,0,3,0, 0,0,1,0,1);
        vecs[10] = mk(0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,1,1);
        vecs[11] = mk(0,7,0,0,7,0,0, 1,0,0,1,1, 0,0,1,1,1);
        vecs[12] = mk(0,0,8,8,0,8,2, 0,1,0,0,0, 2,2,0,0,0);
        vecs[13] = mk(0,0,2,8,0,8,2, 0,0,1,0,0, 1,0,0,0,0);

        clr_inputs();
        rst_n = 0;
        #12;
        chk("reset.MdBusy", 32'(MdBusy), 0);
        chk("reset.StallCycles", StallCycles, 0);
        chk("reset.FlushEvents", FlushEvents, 0);
        chk("reset.StallE", 32'(StallE), 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            clr_inputs();
            Rs1D = vecs[k].rs1d; Rs2D = vecs[k].rs2d; Rs1E = vecs[k].rs1e; Rs2E = vecs[k].rs2e;
            RdE = vecs[k].rde; RdM = vecs[k].rdm; RdW = vecs[k].rdw;
            RegWriteE = vecs[k].rwe; RegWriteM = vecs[k].rwm; RegWriteW = vecs[k].rww;
            ResultSrcE = vecs[k].rsrc; PCSrcE = vecs[k].pc;
            @(negedge clk);
            check_cycle($sformatf("vec%0d", k), vecs[k].fa, vecs[k].fb, vecs[k].st, 0,
                        vecs[k].fd, vecs[k].fe, 0, 0);
        end

        run_div("div");

        // Back-to-back MULs: stall, release, stall, release.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            clr_inputs();
            MulE = 1;
            @(negedge clk);
            check_cycle($sformatf("mul%0d", i), 0, 0, (i % 2) == 0, (i % 2) == 0, 0, 0,
                        (i % 2) == 0, (i % 2) == 1);
        end
        @(posedge clk); #1;
        clr_inputs();
        @(negedge clk);
        check_cycle("mul.after", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while BUSY with cnt=10 (cycle 23 of a DIV).
        for (int i = 1; i <= 23; i++) begin
            @(posedge clk); #1;
            clr_inputs();
            DivE = 1;
            @(negedge clk);
            check_cycle("rstdiv", 0, 0, 1, 1, 0, 0, 1, i >= 2);
        end
        #1 rst_n = 0;
        #1;
        chk("midreset.MdBusy", 32'(MdBusy), 0);
        chk("midreset.StallE", 32'(StallE), 0);
        chk("midreset.FlushM", 32'(FlushM), 0);
        chk("midreset.StallF", 32'(StallF), 0);
        chk("midreset.StallCycles", StallCycles, 0);
        chk("midreset.FlushEvents", FlushEvents, 0);
        exp_stall = 0;
        exp_flush = 0;
        DivE = 0;
        @(negedge clk);
        rst_n = 1;

        run_div("div2");

        // Branch flushes; the narrow instance pins at its maximum.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            clr_inputs();
            PCSrcE = 1;
            @(negedge clk);
            check_cycle($sformatf("br%0d", i), 0, 0, 0, 0, 1, 1, 0, 0);
        end
        @(posedge clk); #1;
        clr_inputs();
        @(negedge clk);
        check_cycle("br.after", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation hazard unit for the 5-stage RV32 pipeline (F/D/E/M/W), extended for the M-extension.
- Keeps E-stage RAW forwarding, load-use stalling and branch flushing.
- Adds a sequential multi-cycle occupancy controller that holds MUL/DIV instructions in E for a parametrised latency and bubbles M.
- Adds saturating stall/flush performance counters; sits beside the datapath and drives all pipeline-register enables and clears.

Parameters:
ADDRESS_WIDTH, 5, register-index width
MUL_LATENCY, 2, total cycles a MUL occupies E (>=1)
DIV_LATENCY, 34, total cycles a DIV/REM occupies E (>=1)
CNT_WIDTH, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  ADDRESS_WIDTH  source registers in D
Rs1E, Rs2E, RdE  in  ADDRESS_WIDTH  source/destination registers in E
RdM, RdW  in  ADDRESS_WIDTH  destinations in M, W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
ResultSrcE  in  2  result select in E; bit0=1 means load
PCSrcE  in  1  taken branch/jump resolved in E
MulE, DivE  in  1  instruction in E is MUL-class / DIV-class (mutually exclusive)
ForwardAE, ForwardBE  out  2  0=regfile, 1=W result, 2=M ALU result
StallF, StallD, StallE  out  1  hold PC, D register, E register
FlushD, FlushE, FlushM  out  1  clear D, E, M registers (synchronous in datapath)
MdBusy  out  1  multi-cycle controller not IDLE
StallCycles, FlushEvents  out  CNT_WIDTH  saturating performance counters

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, cycle counter=0, StallCycles=FlushEvents=0, MdBusy=0. All other outputs are combinational from inputs and state.
- Forwarding (combinational), per operand X in {1,2}: Forward=2 if RsXE==RdM & RegWriteM & RsXE!=0; else 1 if RsXE==RdW & RegWriteW & RsXE!=0; else 0. M has priority over W.
- Load-use: lwStall = ResultSrcE[0] & RegWriteE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Multi-cycle FSM: states IDLE, BUSY, DONE. L = MUL_LATENCY if MulE, else DIV_LATENCY.
  - IDLE & (MulE|DivE) & L>=3: go to BUSY, cnt=L-3.
  - IDLE & (MulE|DivE) & L==2: go to DONE.
  - L==1: no transition, no stall.
  - BUSY: cnt==0 goes to DONE, else cnt-1.
  - DONE: always goes to IDLE, even if MulE/DivE still high. This is the same instruction leaving E and must not restart.
  - Net effect: instruction occupies E exactly L cycles. A back-to-back MD instruction restarts from IDLE the next cycle.
- mdStall = (IDLE & start & L>=2) | BUSY. Not asserted in DONE.
- Outputs:
  - StallF = StallD = lwStall | mdStall
  - StallE = mdStall
  - FlushM = mdStall (bubble into M while E is held)
  - FlushD = PCSrcE & ~mdStall
  - FlushE = (lwStall | PCSrcE) & ~mdStall. E must not be cleared while holding an MD instruction.
  - MdBusy = state!=IDLE
- PCSrcE asserted while state!=IDLE is illegal (the E instruction is MD, not a branch). The bench asserts it never occurs; the RTL masks it as above.
- lwStall and mdStall can both be true only if a load is in E, which excludes MD. No priority conflict; outputs are the OR.
- Counters:
  - StallCycles increments each cycle StallF=1; FlushEvents increments each cycle FlushD=1.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
- Async reset mid-BUSY: FSM returns to IDLE immediately; stalls and FlushM drop in the same cycle; counters clear.
- Counter widths: internal cnt uses $clog2(max(MUL_LATENCY,DIV_LATENCY)+1) bits.

Test Plan:
1. Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=2. Drop RegWriteM -> 1. Rs1E=0 -> 0.
2. Load-use: ResultSrcE=01, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0 for exactly 1 cycle. Same with RdE=0 -> no stall.
3. DIV latency: DIV_LATENCY=34, DivE held high -> StallE=FlushM=1 for 33 cycles, MdBusy high cycles 2-34, release on cycle 34. StallCycles increases by 33.
4. Back-to-back MUL (MUL_LATENCY=2): two MULs consecutive in E -> pattern stall, release, stall, release. No restart in a DONE cycle.
5. Branch flush: PCSrcE=1, FSM IDLE, no MD -> FlushD=FlushE=1, FlushEvents+1. Counter preset to max -> stays at max.
6. Reset at BUSY cnt=10 -> MdBusy, StallE, FlushM=0 immediately; counters 0; subsequent DIV runs full 34 cycles.
